// File: rtl/svm_dwell_scheduler_if.sv
// Handshake and committed-output bundle for the SVM dwell scheduler.
// master = upstream reference source / observer, slave = scheduler.
interface svm_dwell_scheduler_if #(
    parameter int W = 15
);
    logic         IN_VALID;
    logic         IN_READY;
    logic [2:0]   IN_SECTOR;
    logic [W-1:0] IN_T1;
    logic [W-1:0] IN_T2;

    logic         SAMPLE_STROBE;
    logic [2:0]   SECTOR;
    logic [W-1:0] T_0;
    logic [W-1:0] T_1;
    logic [W-1:0] T_2;
    logic [W-1:0] T_7;
    logic         OVERMOD;
    logic         STALE;
    logic         FAULT;

    modport master (
        output IN_VALID, IN_SECTOR, IN_T1, IN_T2,
        input  IN_READY, SAMPLE_STROBE, SECTOR, T_0, T_1, T_2, T_7,
               OVERMOD, STALE, FAULT
    );

    modport slave (
        input  IN_VALID, IN_SECTOR, IN_T1, IN_T2,
        output IN_READY, SAMPLE_STROBE, SECTOR, T_0, T_1, T_2, T_7,
               OVERMOD, STALE, FAULT
    );
endinterface

// File: rtl/svm_dwell_scheduler.sv
// SVM dwell-time scheduler: accepts a (sector, T1, T2) request, scales it
// into the sample period if it over-modulates, splits the remaining zero
// time between V0 and V7, and commits the set on the sample boundary.
module svm_dwell_scheduler #(
    parameter int TAST_PERIOD = 20000,
    parameter int W           = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    svm_dwell_scheduler_if.slave bus
);
    localparam int             CW       = $clog2(TAST_PERIOD);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TAST_PERIOD - 1);
    localparam logic [W:0]     PER      = (W+1)'(TAST_PERIOD);
    localparam int             DCW      = $clog2(W + 1);
    localparam logic [DCW-1:0] DLAST    = DCW'(W - 1);
    localparam logic [W-1:0]   RST_T0   = W'(TAST_PERIOD / 2);
    localparam logic [W-1:0]   RST_T7   = W'(TAST_PERIOD - TAST_PERIOD / 2);

    typedef enum logic [2:0] {IDLE, SUM, DIV, ZERO, PEND} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  cnt;
    logic           strobe;
    logic           xfer;
    logic           bad_sec;

    logic [2:0]     sec_r;
    logic [W-1:0]   t1_r, t2_r;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [W:0]     den_r;
    logic [W:0]     rem_r;
    logic [W-1:0]   nq_r;      // numerator low bits shift out, quotient bits shift in
    logic [DCW-1:0] dcnt;
    logic [W+1:0]   trial;
    logic           ge;
    logic [W+1:0]   rem_nxt;
    logic [W-1:0]   q_nxt;
    logic [W-1:0]   t1p_r, t2p_r, p0_r, p7_r;
    logic           scaled_r;
    logic [W:0]     z, zh;

    assign strobe            = (cnt == CNT_LAST);
    assign bus.SAMPLE_STROBE = strobe;
    assign bus.IN_READY      = RST_N && (state == IDLE);
    assign xfer              = bus.IN_VALID && bus.IN_READY;
    assign bad_sec           = (bus.IN_SECTOR == 3'd0) || (bus.IN_SECTOR == 3'd7);

    assign sum     = {1'b0, t1_r} + {1'b0, t2_r};
    assign prod    = (2*W)'(t1_r) * (2*W)'(TAST_PERIOD);
    assign trial   = {rem_r, nq_r[W-1]};
    assign ge      = (trial >= {1'b0, den_r});
    assign rem_nxt = ge ? (trial - {1'b0, den_r}) : trial;
    assign q_nxt   = {nq_r[W-2:0], ge};
    assign z       = PER - {1'b0, t1p_r} - {1'b0, t2p_r};
    assign zh      = z >> 1;

    // Sample-period counter, wraps at TAST_PERIOD-1.
    always_ff @(posedge CLK) begin
        if (!RST_N || strobe) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer && !bad_sec) state_nxt = SUM;
            SUM:  state_nxt = (sum <= PER) ? ZERO : DIV;
            DIV:  if (dcnt == DLAST) state_nxt = ZERO;
            ZERO: state_nxt = PEND;
            PEND: if (strobe) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request, restoring divide when scaling, zero-time split.
    always_ff @(posedge CLK) begin
        case (state)
            IDLE: if (xfer) begin
                sec_r <= bus.IN_SECTOR;
                t1_r  <= bus.IN_T1;
                t2_r  <= bus.IN_T2;
            end
            SUM: begin
                if (sum <= PER) begin
                    t1p_r    <= t1_r;
                    t2p_r    <= t2_r;
                    scaled_r <= 1'b0;
                end else begin
                    // Quotient fits in W bits, so the top half is already < S.
                    rem_r <= {1'b0, prod[2*W-1:W]};
                    nq_r  <= prod[W-1:0];
                    den_r <= sum;
                    dcnt  <= '0;
                end
            end
            DIV: begin
                rem_r <= rem_nxt[W:0];
                nq_r  <= q_nxt;
                dcnt  <= dcnt + 1'b1;
                if (dcnt == DLAST) begin
                    t1p_r    <= q_nxt;
                    t2p_r    <= PER[W-1:0] - q_nxt;
                    scaled_r <= 1'b1;
                end
            end
            ZERO: begin
                p0_r <= zh[W-1:0];
                p7_r <= W'(z - zh);
            end
            default: ;
        endcase
    end

    // Committed outputs: change only on the boundary edge (or reset).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.SECTOR  <= 3'd1;
            bus.T_0     <= RST_T0;
            bus.T_1     <= '0;
            bus.T_2     <= '0;
            bus.T_7     <= RST_T7;
            bus.OVERMOD <= 1'b0;
            bus.STALE   <= 1'b0;
        end else if (strobe) begin
            if (state == PEND) begin
                bus.SECTOR  <= sec_r;
                bus.T_0     <= p0_r;
                bus.T_1     <= t1p_r;
                bus.T_2     <= t2p_r;
                bus.T_7     <= p7_r;
                bus.OVERMOD <= scaled_r;
                bus.STALE   <= 1'b0;
            end else begin
                bus.STALE   <= 1'b1;
            end
        end
    end

    // Sticky invalid-sector flag.
    always_ff @(posedge CLK) begin
        if (!RST_N)                bus.FAULT <= 1'b0;
        else if (xfer && bad_sec)  bus.FAULT <= 1'b1;
    end
endmodule

// File: tb/tb_svm_dwell_scheduler.sv
// Bench for svm_dwell_scheduler: directed cases plus randomized requests,
// checked against an arithmetic model of the committed dwell set.
module tb_svm_dwell_scheduler;
    localparam int P = 100;
    localparam int W = 15;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    svm_dwell_scheduler_if #(.W(W)) bus();

    svm_dwell_scheduler #(.TAST_PERIOD(P), .W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // expected committed outputs
    int e_sec, e_t0, e_t1, e_t2, e_t7, e_om, e_stale, e_fault;
    // expected pending set
    int p_sec, p_t0, p_t1, p_t2, p_t7, p_om;
    bit p_vld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_sec = 1; e_t1 = 0; e_t2 = 0; e_t0 = P / 2; e_t7 = P - P / 2;
        e_om = 0; e_stale = 0; e_fault = 0; p_vld = 0;
    endtask

    // Scale into the period if needed, then split the zero time.
    task automatic model_req(input int sec, input int t1, input int t2);
        int s, a, b, zz;
        s = t1 + t2;
        if (s <= P) begin a = t1; b = t2; p_om = 0; end
        else begin a = (t1 * P) / s; b = P - a; p_om = 1; end
        zz = P - a - b;
        p_sec = sec; p_t1 = a; p_t2 = b; p_t0 = zz / 2; p_t7 = zz - zz / 2;
        p_vld = 1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".sector"}, 64'(bus.SECTOR), 64'(e_sec));
        chk({tag, ".t0"}, 64'(bus.T_0), 64'(e_t0));
        chk({tag, ".t1"}, 64'(bus.T_1), 64'(e_t1));
        chk({tag, ".t2"}, 64'(bus.T_2), 64'(e_t2));
        chk({tag, ".t7"}, 64'(bus.T_7), 64'(e_t7));
        chk({tag, ".overmod"}, 64'(bus.OVERMOD), 64'(e_om));
        chk({tag, ".stale"}, 64'(bus.STALE), 64'(e_stale));
        chk({tag, ".fault"}, 64'(bus.FAULT), 64'(e_fault));
    endtask

    // Wait for the boundary, apply the model's commit rule, check outputs.
    task automatic wait_strobe(input string tag, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.SAMPLE_STROBE !== 1'b1 && n < 3 * P);
        chk({tag, ".strobe_seen"}, 64'(bus.SAMPLE_STROBE), 64'(1));
        @(negedge CLK);
        chk({tag, ".strobe_pulse"}, 64'(bus.SAMPLE_STROBE), 64'(0));
        if (p_vld) begin
            e_sec = p_sec; e_t0 = p_t0; e_t1 = p_t1; e_t2 = p_t2; e_t7 = p_t7;
            e_om = p_om; e_stale = 0; p_vld = 0;
        end else begin
            e_stale = 1;
        end
        check_outs(tag);
    endtask

    task automatic send(input string tag, input int sec, input int t1, input int t2);
        int n;
        @(negedge CLK);
        bus.IN_VALID  = 1'b1;
        bus.IN_SECTOR = 3'(sec);
        bus.IN_T1     = W'(t1);
        bus.IN_T2     = W'(t2);
        n = 0;
        while (bus.IN_READY !== 1'b1 && n < 4 * W) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, ".ready"}, 64'(bus.IN_READY), 64'(1));
        @(posedge CLK);
        #1 bus.IN_VALID = 1'b0;
        if (sec == 0 || sec == 7) e_fault = 1;
        else model_req(sec, t1, t2);
    endtask

    initial begin
        int n, r, sec, t1, t2;
        bus.IN_VALID = 1'b0; bus.IN_SECTOR = 3'd0; bus.IN_T1 = '0; bus.IN_T2 = '0;
        model_reset();

        // reset state
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst.ready", 64'(bus.IN_READY), 64'(0));
        chk("rst.strobe", 64'(bus.SAMPLE_STROBE), 64'(0));
        check_outs("rst");
        RST_N = 1'b1;

        // unscaled, even zero time
        send("d30", 3, 30, 20);
        repeat (30) @(negedge CLK);
        check_outs("d30.hold");
        wait_strobe("d30", n);

        // overmodulation
        send("d31", 5, 90, 60);
        wait_strobe("d31", n);

        // odd zero time
        send("d32", 2, 30, 21);
        wait_strobe("d32", n);

        // no vector for one period, then recovery
        wait_strobe("stale", n);
        chk("stale.period", 64'(n), 64'(P - 1));
        send("recov", 6, 10, 10);
        wait_strobe("recov", n);

        // invalid sectors: sticky fault, outputs unaffected
        send("bad7", 7, 40, 40);
        @(negedge CLK);
        chk("bad7.fault", 64'(bus.FAULT), 64'(1));
        chk("bad7.ready", 64'(bus.IN_READY), 64'(1));
        wait_strobe("bad7", n);
        send("bad0", 0, 1, 1);
        wait_strobe("bad0", n);

        // exact-fit boundary: S == P stays unscaled
        send("fit", 1, 60, 40);
        wait_strobe("fit", n);
        // just over: S == P+1 scales
        send("over", 4, 61, 40);
        wait_strobe("over", n);

        // randomized requests
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r == 1) begin
                send("rnd.bad", ($urandom_range(0, 1) != 0) ? 7 : 0, 5, 5);
            end else if (r != 0) begin
                sec = $urandom_range(1, 6);
                if (r < 5) begin
                    t1 = $urandom_range(0, 60); t2 = $urandom_range(0, 60);
                end else begin
                    t1 = $urandom_range(0, 32767); t2 = $urandom_range(0, 32767);
                end
                send("rnd", sec, t1, t2);
            end
            wait_strobe("rnd", n);
        end

        // reset while dividing discards the pending vector
        send("rstdiv", 2, 20000, 15000);
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rstdiv.ready", 64'(bus.IN_READY), 64'(0));
        RST_N = 1'b1;
        model_reset();
        check_outs("rstdiv");
        wait_strobe("rstdiv.next", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/svm_dwell_scheduler.md
SVM_DWELL_SCHEDULER -- requirements
Module: svm_dwell_scheduler

Interface
REQ-001 The module SHALL have parameter TAST_PERIOD, default 20000, meaning clock cycles per switching sample period (100 MHz / 5 kHz).
REQ-002 The module SHALL have parameter W, default 15, meaning the width of every dwell-time value in clock cycles.
REQ-003 The module SHALL have port CLK  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RST_N  input  1  meaning synchronous, active-low reset.
REQ-005 The module SHALL have port IN_VALID  input  1  meaning upstream offers a new reference vector.
REQ-006 The module SHALL have port IN_READY  output  1  meaning the scheduler accepts a vector this cycle.
REQ-007 The module SHALL have port IN_SECTOR  input  3  meaning requested sector; valid values are 1..6.
REQ-008 The module SHALL have ports IN_T1 and IN_T2  input  W each  meaning requested active-vector dwell times.
REQ-009 The module SHALL have port SAMPLE_STROBE  output  1  meaning a one-cycle pulse on the last cycle of each sample period.
REQ-010 The module SHALL have port SECTOR  output  3  meaning the committed sector.
REQ-011 The module SHALL have ports T_0, T_1, T_2 and T_7  output  W each  meaning the committed dwell times fed to the vector timing generator.
REQ-012 The module SHALL have port OVERMOD  output  1  meaning the last committed vector was scaled.
REQ-013 The module SHALL have port STALE  output  1  meaning the last boundary had no new vector to commit.
REQ-014 The module SHALL have port FAULT  output  1  meaning sticky flag: an invalid sector was received.

Function
REQ-015 The sample counter SHALL count 0..TAST_PERIOD-1 and wrap; SAMPLE_STROBE SHALL be 1 exactly when the count equals TAST_PERIOD-1.
REQ-016 The FSM SHALL have the states IDLE, SUM, DIV, ZERO and PEND.
REQ-017 IN_READY SHALL be 1 only in IDLE; a transfer occurs on IN_VALID&&IN_READY, latching IN_SECTOR, IN_T1 and IN_T2, then IDLE->SUM.
REQ-018 On a transfer with IN_SECTOR of 0 or 7, the vector SHALL be discarded, FAULT SHALL be set, and the FSM SHALL stay in IDLE.
REQ-019 In SUM, S=T1+T2 SHALL be computed at W+1 bits; if S<=TAST_PERIOD the FSM SHALL go to ZERO unscaled, otherwise to DIV.
REQ-020 In DIV, a restoring divider SHALL compute T1'=floor(T1*TAST_PERIOD/S), one quotient bit per cycle over W cycles, and then set T2'=TAST_PERIOD-T1'; the scaled flag SHALL then be set.
REQ-021 In ZERO, Z=TAST_PERIOD-T1'-T2', pending T_0=floor(Z/2) and pending T_7=Z-floor(Z/2) SHALL be computed, so that T_0+T_1+T_2+T_7 equals TAST_PERIOD exactly; the FSM then goes to PEND.
REQ-022 In PEND the FSM SHALL hold the pending set until SAMPLE_STROBE; on that cycle all outputs SHALL update together on the next edge and the FSM SHALL return to IDLE.
REQ-023 If SAMPLE_STROBE occurs with the FSM not in PEND, the outputs SHALL hold, STALE SHALL be 1 until the next boundary, and any in-flight computation SHALL continue.
REQ-024 On a boundary with a commit, STALE SHALL clear and OVERMOD SHALL take the scaled flag of the committed vector.
REQ-025 The outputs SHALL never change except on the edge following SAMPLE_STROBE, or on reset.
REQ-026 Worst-case latency from transfer to PEND SHALL be W+3 cycles, and TAST_PERIOD SHALL be at least W+4.

Reset
REQ-027 With RST_N=0 at a rising edge: FSM=IDLE, sample counter=0, SECTOR=1, T_1=T_2=0, T_0=TAST_PERIOD/2 (floor), T_7=TAST_PERIOD-T_0, SAMPLE_STROBE=0, OVERMOD=0, STALE=0 and FAULT=0.
REQ-028 Reset asserted mid-computation or in PEND SHALL discard the pending vector.
REQ-029 IN_READY SHALL be 0 while RST_N=0.

Verification
REQ-030 With TAST_PERIOD=100, send sector 3, T1=30, T2=20 -> after the next strobe: SECTOR=3, T_1=30, T_2=20, T_0=25, T_7=25, OVERMOD=0.
REQ-031 With TAST_PERIOD=100, send T1=90, T2=60 -> after commit: T_1=60, T_2=40, T_0=0, T_7=0, OVERMOD=1.
REQ-032 With TAST_PERIOD=100, send T1=30, T2=21 -> after commit: T_0=24, T_7=25.
REQ-033 With no vector sent for one period -> STALE=1 after the strobe and outputs unchanged; a vector sent in the next period -> STALE=0 after that period's strobe.
REQ-034 Send sector 7 -> FAULT=1, which persists until RST_N=0, and outputs are unchanged.
REQ-035 Assert reset while in DIV -> the reset values of REQ-027 apply, and no commit occurs at the next strobe.
